// File: rtl/la_loader_pkg.sv
// ============================================================================
// la_loader_pkg : shared encodings for the instruction-memory loader | rev 1.0
// ============================================================================
`default_nettype none

package la_loader_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_HALT  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int STAT_STATE_MSB = 31;
  localparam int STAT_STATE_LSB = 30;
  localparam int STAT_FULL      = 29;
  localparam int STAT_OVF       = 28;
  localparam int STAT_RUN_ERR   = 27;
  localparam int STAT_ACK       = 26;
  localparam int STAT_CNT_MSB   = 8;

  function automatic logic [31:0] pack_status(
    input logic [1:0] st,
    input logic       full,
    input logic       ovf,
    input logic       run_err,
    input logic       ack,
    input logic [8:0] cnt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_STATE_MSB:STAT_STATE_LSB] = st;
    s[STAT_FULL]                     = full;
    s[STAT_OVF]                      = ovf;
    s[STAT_RUN_ERR]                  = run_err;
    s[STAT_ACK]                      = ack;
    s[STAT_CNT_MSB:0]                = cnt;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/la_imem_loader_toggle_sync.sv
// ============================================================================
// toggle_sync : 2-flop synchronizer with toggle edge detect | rev 1.0
// ============================================================================
`default_nettype none

module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic evt
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Either edge of the host toggle is one command.
  assign evt = sync2_q ^ prev_q;

endmodule

`default_nettype wire

// File: rtl/la_imem_loader.sv
// ============================================================================
// la_imem_loader : host-driven instruction-memory loader and core run control | rev 1.0
// ============================================================================
`default_nettype none

module la_imem_loader
  import la_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              la_cmd_toggle,
  input  logic [1:0]        la_cmd_op,
  input  logic [DATA_W-1:0] la_cmd_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              core_run,
  output logic [31:0]       la_status
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic              cmd_evt;
  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] ptr_q,     ptr_d;
  logic [ADDR_W:0]   count_q,   count_d;
  logic              full_q,    full_d;
  logic              ovf_q,     ovf_d;
  logic              rerr_q,    rerr_d;
  logic              ack_q,     ack_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              crst_q,    crst_d;
  logic              crun_q,    crun_d;
  logic [31:0]       status_q,  status_d;

  toggle_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (la_cmd_toggle),
    .evt      (cmd_evt)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    rerr_d   = rerr_q;
    ack_d    = ack_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    crst_d   = crst_q;
    crun_d   = crun_q;
    // Status lags the command by one cycle, reflecting the registered state.
    status_d = pack_status(state_q, full_q, ovf_q, rerr_q, ack_q, 9'(count_q));

    if (cmd_evt) begin
      ack_d = ~ack_q;
      case (la_cmd_op)
        CMD_WRITE: begin
          if (state_q == ST_RUN) begin
            rerr_d = 1'b1;
          end else if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = la_cmd_data;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            full_d  = ((count_q + 1'b1) == DEPTH);
            state_d = ST_LOAD;
          end
        end
        CMD_RUN: begin
          if (state_q != ST_RUN) begin
            state_d = ST_RUN;
            crst_d  = 1'b0;
            crun_d  = 1'b1;
          end
        end
        CMD_HALT: begin
          state_d = ST_IDLE;
          crst_d  = 1'b1;
          crun_d  = 1'b0;
          ptr_d   = '0;
          count_d = '0;
          full_d  = 1'b0;
          ovf_d   = 1'b0;
          rerr_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rerr_q   <= 1'b0;
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      crst_q   <= 1'b1;
      crun_q   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      rerr_q   <= rerr_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      crst_q   <= crst_d;
      crun_q   <= crun_d;
      status_q <= status_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = crst_q;
  assign core_run   = crun_q;
  assign la_status  = status_q;

endmodule

`default_nettype wire

// File: tb/tb_la_imem_loader.sv
// ============================================================================
// tb_la_imem_loader : scoreboard bench for the instruction-memory loader | rev 1.0
// ============================================================================
`default_nettype none

module tb_la_imem_loader;

  logic        clk;
  logic        rst;
  logic        la_cmd_toggle;
  logic [1:0]  la_cmd_op;
  logic [31:0] la_cmd_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        core_run;
  logic [31:0] la_status;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [31:0] st;
    logic        crst;
    logic        crun;
    int          cyc;
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];

  la_imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .la_cmd_toggle (la_cmd_toggle),
    .la_cmd_op     (la_cmd_op),
    .la_cmd_data   (la_cmd_data),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .core_rst      (core_rst),
    .core_run      (core_run),
    .la_status     (la_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one command and pace on the ack bit; expectations go to the scoreboard.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] data, input bit exp_we,
                        input logic [7:0] exp_addr, input logic [31:0] exp_st,
                        input logic exp_crst, input logic exp_crun);
    int  k;
    bit  got;
    wr_t w;
    st_t s;
    @(negedge clk);
    la_cmd_op     = op;
    la_cmd_data   = data;
    k             = cyc;
    la_cmd_toggle = ~la_cmd_toggle;
    if (exp_we) begin
      w.addr = exp_addr; w.data = data; w.cyc = k + 3;
      wr_q.push_back(w);
    end
    s.st = exp_st; s.crst = exp_crst; s.crun = exp_crun; s.cyc = k + 4;
    st_q.push_back(s);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (la_status[26] == exp_st[26]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: status 0x%08h never showed ack %0b", la_status, exp_st[26]);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or flips ack.
  logic prev_ack = 1'b0;
  initial begin
    wr_t w;
    st_t s;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_ack = la_status[26];
        continue;
      end
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_imem_we", {56'd0, imem_addr}, 64'hFFFF);
        end else begin
          w = wr_q.pop_front();
          check("imem_addr",  64'(imem_addr),  64'(w.addr));
          check("imem_wdata", 64'(imem_wdata), 64'(w.data));
          check("imem_we_cycle", 64'(cyc), 64'(w.cyc));
        end
      end
      if (la_status[26] != prev_ack) begin
        if (st_q.size() == 0) begin
          check("unexpected_ack", 64'(la_status), 64'hFFFF_FFFF_FFFF);
        end else begin
          s = st_q.pop_front();
          check("la_status",    64'(la_status), 64'(s.st));
          check("core_rst",     64'(core_rst),  64'(s.crst));
          check("core_run",     64'(core_run),  64'(s.crun));
          check("status_cycle", 64'(cyc),       64'(s.cyc));
        end
      end
      prev_ack = la_status[26];
    end
  end

  initial begin
    logic [31:0] exp_st;
    rst           = 1'b1;
    la_cmd_toggle = 1'b0;
    la_cmd_op     = 2'b00;
    la_cmd_data   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_status",   64'(la_status),  64'h0);
    check("reset_core_rst", 64'(core_rst),   64'h1);
    check("reset_core_run", 64'(core_run),   64'h0);
    check("reset_we",       64'(imem_we),    64'h0);
    check("reset_addr",     64'(imem_addr),  64'h0);
    check("reset_wdata",    64'(imem_wdata), 64'h0);

    // Reset while a WRITE sits in the synchronizer: nothing may come out.
    la_cmd_op     = 2'b01;
    la_cmd_data   = 32'hCAFE_F00D;
    la_cmd_toggle = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    la_cmd_toggle = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_status",   64'(la_status), 64'h0);
    check("midrst_core_rst", 64'(core_rst),  64'h1);

    // Load three words.
    do_cmd(2'b01, 32'h0050_0093, 1'b1, 8'd0, 32'h4400_0001, 1'b1, 1'b0);
    do_cmd(2'b01, 32'h0010_0113, 1'b1, 8'd1, 32'h4000_0002, 1'b1, 1'b0);
    do_cmd(2'b01, 32'h0020_81B3, 1'b1, 8'd2, 32'h4400_0003, 1'b1, 1'b0);
    do_cmd(2'b00, 32'h0,         1'b0, 8'd0, 32'h4000_0003, 1'b1, 1'b0);
    do_cmd(2'b11, 32'h0,         1'b0, 8'd0, 32'h0400_0000, 1'b1, 1'b0);

    // Fill all 256 words; ack is 1 after the HALT, so after write i it equals i[0].
    for (int i = 0; i < 256; i++) begin
      exp_st = 32'h4000_0000 | (32'(i & 1) << 26) | 32'(i + 1);
      if (i == 255) exp_st = exp_st | 32'h2000_0000;
      do_cmd(2'b01, 32'h1000_0000 + 32'(i * 7), 1'b1, 8'(i), exp_st, 1'b1, 1'b0);
    end
    do_cmd(2'b01, 32'hBAD0_0001, 1'b0, 8'd0, 32'h7000_0100, 1'b1, 1'b0);
    do_cmd(2'b10, 32'h0,         1'b0, 8'd0, 32'hB400_0100, 1'b0, 1'b1);
    do_cmd(2'b01, 32'hBAD0_0002, 1'b0, 8'd0, 32'hB800_0100, 1'b0, 1'b1);
    do_cmd(2'b10, 32'h0,         1'b0, 8'd0, 32'hBC00_0100, 1'b0, 1'b1);
    do_cmd(2'b11, 32'h0,         1'b0, 8'd0, 32'h0000_0000, 1'b1, 1'b0);
    do_cmd(2'b01, 32'hDEAD_BEEF, 1'b1, 8'd0, 32'h4400_0001, 1'b1, 1'b0);
    do_cmd(2'b00, 32'h0,         1'b0, 8'd0, 32'h4000_0001, 1'b1, 1'b0);

    repeat (6) @(negedge clk);
    check("wr_queue_drained", 64'(wr_q.size()), 64'h0);
    check("st_queue_drained", 64'(st_q.size()), 64'h0);
    check("final_we_idle",    64'(imem_we),     64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/la_imem_loader.md
Name: la_imem_loader

Overview:
- Host-side program loader that sits directly upstream of the RISC_V core.
- The host issues word-at-a-time commands over logic-analyzer lines using a toggle handshake.
- The block writes each instruction into the core's instruction memory port, then releases the core into run.
- Status is returned to the host on a 32-bit word routed to la_data_out.

Parameters:
ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction word width

Ports:
clk  in  1  core clock (driven from LA bit 48)
rst  in  1  asynchronous, active-high reset
la_cmd_toggle  in  1  host flips this to issue one command; asynchronous to clk
la_cmd_op  in  2  command: 00 NOP, 01 WRITE, 10 RUN, 11 HALT
la_cmd_data  in  DATA_W  instruction word for WRITE
imem_we  out  1  instruction-memory write strobe, one-cycle pulse
imem_addr  out  ADDR_W  write word address
imem_wdata  out  DATA_W  write data
core_rst  out  1  holds the core in reset while high
core_run  out  1  core execution enable
la_status  out  32  status word returned to the host

Behaviour:
- Reset (asynchronous, active-high) drives:
  - state = IDLE, ptr = 0, count = 0, all flags = 0, ack = 0
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - core_rst = 1, core_run = 0
  - sync flops = 0
  - Reset asserted mid-load abandons the sequence; no imem_we pulse is emitted after reset asserts.
- Command detection:
  - la_cmd_toggle passes through a 2-flop synchronizer, then a previous-value flop.
  - cmd_evt = sync2 XOR prev.
  - If the toggle flips before clock edge E0, cmd_evt is high during the cycle after E1.
  - la_cmd_op and la_cmd_data are sampled directly at E2, and all command effects register at E2.
  - Latency is therefore 3 rising edges from toggle to outputs.
- Host protocol: hold op/data stable from before the toggle flip until the ack bit changes. One toggle flip is one command; flips arriving faster than ack are unsupported.
- ack flips at E2 for every command, including NOP and rejected commands.
- State machine: IDLE, LOAD, RUN.
  - WRITE in IDLE/LOAD, not full:
    - imem_we = 1 for exactly one cycle; imem_addr = ptr, imem_wdata = data
    - ptr++, count++, state = LOAD
    - full = 1 when count reaches DEPTH; ptr then wraps to 0 but is unused
  - WRITE in IDLE/LOAD, full: no write; overflow sticky flag set; ptr and count unchanged.
  - WRITE in RUN: no write; run_err sticky flag set.
  - RUN in IDLE/LOAD: state = RUN, core_rst = 0, core_run = 1, from the same edge E2.
  - RUN in RUN: no effect besides ack.
  - HALT in any state:
    - state = IDLE, core_rst = 1, core_run = 0
    - ptr, count, full, overflow and run_err cleared
    - imem contents untouched
  - NOP: ack only.
- imem_addr and imem_wdata hold their last written values between writes.
- la_status is registered and updates the cycle after each command:
  - [31:30] state (IDLE = 0, LOAD = 1, RUN = 2)
  - [29] full
  - [28] overflow
  - [27] run_err
  - [26] ack
  - [8:0] count (0..256)
  - all other bits 0

Decomposition:
- Shared package la_loader_pkg holds:
  - op encodings CMD_NOP, CMD_WRITE, CMD_RUN, CMD_HALT
  - state encodings ST_IDLE, ST_LOAD, ST_RUN
  - status bit positions
- Sub-module toggle_sync: 2-flop synchronizer plus edge detect, with ports clk, rst, async_in, evt.
- Top-level loader holds the FSM, pointer/count and output registers (about 200 lines).

Test Plan:
- Reset mid-operation: assert rst while a WRITE is in the sync pipeline -> no imem_we; la_status = 0x00000000; core_rst = 1.
- Load 3 words: WRITE 0x00500093, 0x00100113, 0x002081B3 with toggle/ack pacing -> 3 one-cycle imem_we pulses at addr 0, 1, 2 with matching data, each 3 edges after its toggle; status = 0x44000003 after the third (state LOAD, ack = 1, count = 3).
- Fill and overflow: 256 WRITEs -> full = 1, count = 256. A 257th WRITE -> no imem_we; overflow = 1; ack flips.
- RUN and write-in-RUN: RUN after load -> core_rst = 0, core_run = 1, state = 2. A subsequent WRITE -> no imem_we; run_err = 1.
- HALT recovery: HALT from RUN with errors set -> state IDLE, core_rst = 1, count/flags 0. The next WRITE goes to imem_addr 0.
- NOP: ack flips; imem_we stays 0; all other status bits unchanged.
